// File: rtl/clk_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_period_meter_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// Result bus of the clock period meter: producer drives, monitors consume.
interface clk_period_meter_if #(
    parameter int unsigned CNT_W = clk_period_meter_pkg::CNT_W_DEF
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             meas_level;

    modport master (output period, high_time, valid, timeout, meas_level);
    modport slave  (input  period, high_time, valid, timeout, meas_level);
endinterface

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus rise/fall detection.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edges come from one bit of history, so rise and fall are mutually exclusive.
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;
endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk_in cycles.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                en,
    input  logic                meas_clk,
    clk_period_meter_if.master  res
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_e     state, state_nxt;
    logic             level, rise, fall;
    logic [CNT_W-1:0] cnt, hi_cap;
    logic             hi_seen;
    logic [CNT_W-1:0] period_q, high_time_q;
    logic             valid_q, timeout_q;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (meas_clk),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Disable dominates; saturation without a rise drops back to re-arm.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_ARM;
                ST_ARM:     if (rise) state_nxt = ST_MEASURE;
                ST_MEASURE: if (!rise && (cnt == CNT_MAX)) state_nxt = ST_ARM;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            hi_cap      <= '0;
            hi_seen     <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: cnt <= '0;
                ST_ARM: begin
                    if (en && rise) begin
                        cnt     <= CNT_W'(1);
                        hi_seen <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (en && rise) begin
                        period_q    <= cnt;
                        high_time_q <= hi_seen ? hi_cap : '0;
                        valid_q     <= 1'b1;
                        timeout_q   <= 1'b0;
                        cnt         <= CNT_W'(1);
                        hi_seen     <= 1'b0;
                    end else if (en) begin
                        if (fall) begin
                            hi_cap  <= cnt;
                            hi_seen <= 1'b1;
                        end
                        if (cnt == CNT_MAX) timeout_q <= 1'b1;
                        else                cnt       <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign res.period     = period_q;
    assign res.high_time  = high_time_q;
    assign res.valid      = valid_q;
    assign res.timeout    = timeout_q;
    assign res.meas_level = level;
endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter checked against an edge-timestamp model.
module tb_clk_period_meter;
    import clk_period_meter_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned S     = 2;
    localparam int          MAXV  = (1 << CNT_W) - 1;
    localparam int          HMAX  = 8192;
    localparam int          M_IDLE = 0, M_ARM = 1, M_MEAS = 2;

    logic clk_in = 1'b0;
    logic rst_n, en, meas_clk;

    clk_period_meter_if #(.CNT_W(CNT_W)) res ();

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .meas_clk (meas_clk),
        .res      (res)
    );

    always #10 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Model expectations.
    logic [CNT_W-1:0] e_period = '0;
    logic [CNT_W-1:0] e_high   = '0;
    logic             e_valid  = 1'b0;
    logic             e_to     = 1'b0;

    // Model state: meas_clk as sampled on each clk_in edge plus event timestamps.
    bit hist [HMAX];
    int cyc   = 0;
    int mode  = M_IDLE;
    int r_t   = 0;
    int f_t   = 0;
    bit fseen = 1'b0;

    // Monitor log of valid results.
    int vq[$];
    int hq[$];
    int ncyc      = 0;
    int last_vn   = 0;
    int last_gap  = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: sync delay is a pure S-cycle shift of the sampled history.
    initial begin : model
        bit s, sd, rise, fall;
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (rst_n !== 1'b1) begin
                mode    = M_IDLE;
                e_period = '0; e_high = '0; e_valid = 1'b0; e_to = 1'b0;
                fseen   = 1'b0;
                for (int k = 1; k <= int'(S) + 1; k++)
                    if (cyc - k >= 0) hist[(cyc - k) % HMAX] = 1'b0;
            end else begin
                hist[cyc % HMAX] = meas_clk;
                s    = (cyc >= int'(S))     ? hist[(cyc - int'(S)) % HMAX]     : 1'b0;
                sd   = (cyc >= int'(S) + 1) ? hist[(cyc - int'(S) - 1) % HMAX] : 1'b0;
                rise = s & ~sd;
                fall = ~s & sd;
                e_valid = 1'b0;
                if (!en) begin
                    mode = M_IDLE;
                end else if (mode == M_IDLE) begin
                    mode = M_ARM;
                end else if (mode == M_ARM) begin
                    if (rise) begin r_t = cyc; fseen = 1'b0; mode = M_MEAS; end
                end else begin
                    if (rise) begin
                        e_period = CNT_W'(cyc - r_t);
                        e_high   = fseen ? CNT_W'(f_t - r_t) : '0;
                        e_valid  = 1'b1;
                        e_to     = 1'b0;
                        r_t      = cyc;
                        fseen    = 1'b0;
                    end else begin
                        if (fall) begin f_t = cyc; fseen = 1'b1; end
                        if (cyc - r_t >= MAXV) begin e_to = 1'b1; mode = M_ARM; end
                    end
                end
                cyc++;
            end
        end
    end

    // Per-cycle compare against the model, plus a log of every valid result.
    initial begin : compare
        forever begin
            @(negedge clk_in);
            ncyc++;
            tests++;
            if (res.valid !== e_valid || res.period !== e_period ||
                res.high_time !== e_high || res.timeout !== e_to) begin
                fails++;
                $display("FAIL cycle_compare @%0t: valid/period/high/timeout got %0b/%0d/%0d/%0b expected %0b/%0d/%0d/%0b",
                         $time, res.valid, res.period, res.high_time, res.timeout,
                         e_valid, e_period, e_high, e_to);
            end
            if (res.valid === 1'b1) begin
                vq.push_back(int'(res.period));
                hq.push_back(int'(res.high_time));
                last_gap = ncyc - last_vn;
                last_vn  = ncyc;
            end
        end
    end

    task automatic gen(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            meas_clk = 1'b1;
            repeat (h) @(negedge clk_in);
            meas_clk = 1'b0;
            repeat (l) @(negedge clk_in);
        end
    endtask

    initial begin : stim
        int base;
        int nv_off;
        rst_n = 1'b0; en = 1'b0; meas_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("reset_period",  int'(res.period),    0);
        chk("reset_high",    int'(res.high_time), 0);
        chk("reset_valid",   int'(res.valid),     0);
        chk("reset_timeout", int'(res.timeout),   0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk_in);

        // Divide-by-12, 50% duty.
        base = vq.size();
        gen(6, 6, 8);
        chk("div12_count",  vq.size() - base, 7);
        chk("div12_period", vq[$], 12);
        chk("div12_high",   hq[$], 6);
        chk("div12_gap",    last_gap, 12);
        chk("div12_timeout", int'(res.timeout), 0);

        // Odd divide-by-5.
        base = vq.size();
        gen(3, 2, 10);
        chk("div5_count",  vq.size() - base, 10);
        chk("div5_first",  vq[base], 12);
        chk("div5_period", vq[$], 5);
        chk("div5_high",   hq[$], 3);

        // Retune 12 -> 8 at a rising edge.
        gen(6, 6, 4);
        base = vq.size();
        gen(4, 4, 4);
        chk("retune_count",   vq.size() - base, 4);
        chk("retune_close12", vq[base], 12);
        chk("retune_period8", vq[base + 1], 8);
        chk("retune_high4",   hq[base + 1], 4);

        // Input stops: timeout, results held.
        base = vq.size();
        repeat (300) @(negedge clk_in);
        chk("stuck_timeout", int'(res.timeout),   1);
        chk("stuck_period",  int'(res.period),    8);
        chk("stuck_high",    int'(res.high_time), 4);
        chk("stuck_novalid", vq.size() - base, 0);

        // Restart: re-arm, then first valid clears timeout.
        base = vq.size();
        gen(6, 6, 4);
        chk("restart_count",   vq.size() - base, 3);
        chk("restart_period",  vq[$], 12);
        chk("restart_timeout", int'(res.timeout), 0);

        // Rise exactly on the saturating cycle is a valid full-scale period.
        gen(100, 155, 3);
        chk("sat_period",  vq[$], MAXV);
        chk("sat_high",    hq[$], 100);
        chk("sat_timeout", int'(res.timeout), 0);

        // Enable dropped mid-measurement.
        nv_off = 0;
        fork
            gen(6, 6, 6);
            begin
                repeat (17) @(negedge clk_in);
                en = 1'b0;
                repeat (15) begin
                    @(negedge clk_in);
                    if (res.valid === 1'b1) nv_off++;
                end
                en = 1'b1;
            end
        join
        chk("en_off_novalid", nv_off, 0);
        chk("en_back_period", vq[$], 12);
        chk("en_back_high",   hq[$], 6);

        // Asynchronous reset between clock edges.
        fork
            gen(6, 6, 8);
            begin
                repeat (30) @(posedge clk_in);
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_period",  int'(res.period),    0);
                chk("async_rst_high",    int'(res.high_time), 0);
                chk("async_rst_valid",   int'(res.valid),     0);
                chk("async_rst_timeout", int'(res.timeout),   0);
                @(negedge clk_in);
                rst_n = 1'b1;
            end
        join
        chk("post_rst_period", vq[$], 12);

        // Random waveforms.
        for (int i = 0; i < 8; i++)
            gen(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(3, 6)));
        gen(5, 5, 3);
        chk("rand_tail_period", vq[$], 10);
        chk("rand_tail_high",   hq[$], 5);

        repeat (5) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
